// File: rtl/miller_rabin_pkg.sv
// Shared types and constants for the Miller-Rabin primality tester.
// Optional MR_ROUND_COUNT_EN adds a completed-round counter output on the core interface.
package miller_rabin_pkg;

  localparam int MR_MAX_ROUNDS = 12;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_DECOMP,
    ST_POW,
    ST_SQR,
    ST_NEXT,
    ST_DONE
  } mr_state_e;

  // Entry 0 is the first base tried.
  localparam logic [MR_MAX_ROUNDS-1:0][5:0] MR_WITNESS = {
    6'd37, 6'd31, 6'd29, 6'd23, 6'd19, 6'd17,
    6'd13, 6'd11, 6'd7,  6'd5,  6'd3,  6'd2
  };

  function automatic logic [3:0] mr_clamp_rounds(input logic [127:0] acc);
    if (acc == 128'd0)       return 4'd1;
    else if (acc >= 128'd12) return 4'd12;
    else                     return acc[3:0];
  endfunction

endpackage

// File: rtl/miller_rabin_core_if.sv
// Candidate/verdict bus of the Miller-Rabin core.
// With MR_ROUND_COUNT_EN the bus also carries rounds_done.
interface miller_rabin_core_if #(
  parameter int WORDSIZE = 31
);
  logic [WORDSIZE-1:0]   start_number;
  logic [2*WORDSIZE-1:0] accuracy;
  logic                  prime;
  logic                  finish;
`ifdef MR_ROUND_COUNT_EN
  logic [3:0]            rounds_done;

  modport master (output start_number, output accuracy,
                  input prime, input finish, input rounds_done);
  modport slave  (input start_number, input accuracy,
                  output prime, output finish, output rounds_done);
`else
  modport master (output start_number, output accuracy,
                  input prime, input finish);
  modport slave  (input start_number, input accuracy,
                  output prime, output finish);
`endif
endinterface

// File: rtl/miller_rabin_core_mod_mul.sv
// Shift-add modular multiplier: res = a*b mod n, a,b < n, MSB-first over b.
// One load cycle on start, then WORDSIZE shift-add cycles; done pulses with res valid.
module mr_mod_mul #(
  parameter int WORDSIZE = 31
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  input  logic [WORDSIZE-1:0] a,
  input  logic [WORDSIZE-1:0] b,
  input  logic [WORDSIZE-1:0] n,
  output logic                done,
  output logic [WORDSIZE-1:0] res
);
  logic [WORDSIZE:0]   acc, dbl, dbl_r, sum, sum_r, acc_next, n_ext;
  logic [WORDSIZE-1:0] a_q, b_q, n_q;
  logic [6:0]          cnt;
  logic                busy;

  // acc < n < 2^WORDSIZE, so doubling and adding both fit in WORDSIZE+1 bits.
  always_comb begin
    n_ext    = {1'b0, n_q};
    dbl      = acc << 1;
    dbl_r    = (dbl >= n_ext) ? dbl - n_ext : dbl;
    sum      = dbl_r + {1'b0, a_q};
    sum_r    = (sum >= n_ext) ? sum - n_ext : sum;
    acc_next = b_q[WORDSIZE-1] ? sum_r : dbl_r;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      acc  <= '0;
      a_q  <= '0;
      b_q  <= '0;
      n_q  <= '0;
      cnt  <= '0;
      busy <= 1'b0;
      done <= 1'b0;
    end else begin
      done <= 1'b0;
      if (start) begin
        acc  <= '0;
        a_q  <= a;
        b_q  <= b;
        n_q  <= n;
        cnt  <= 7'(WORDSIZE);
        busy <= 1'b1;
      end else if (busy) begin
        acc <= acc_next;
        b_q <= b_q << 1;
        cnt <= cnt - 7'd1;
        if (cnt == 7'd1) begin
          busy <= 1'b0;
          done <= 1'b1;
        end
      end
    end
  end

  assign res = acc[WORDSIZE-1:0];

endmodule

// File: rtl/miller_rabin_core.sv
// Iterative Miller-Rabin tester over fixed witnesses 2..37, driving mr_mod_mul.
// Optional MR_ROUND_COUNT_EN exposes rounds_done (completed or skipped rounds).
module miller_rabin_core
  import miller_rabin_pkg::*;
#(
  parameter int WORDSIZE = 31
) (
  input  logic               clk,
  input  logic               reset,
  miller_rabin_core_if.slave bus
);
  localparam int                BW      = $clog2(WORDSIZE);
  localparam logic [BW-1:0]     BIT_TOP = BW'(WORDSIZE - 1);

  mr_state_e           state, state_next;
  logic [WORDSIZE-1:0] n_q, nm1, d, x, base, mul_a, mul_b, mul_res;
  logic [3:0]          rounds_q, round_cnt;
  logic [6:0]          s, sq_left;
  logic [BW-1:0]       bit_idx;
  logic                mul_phase, mul_busy, mul_start, mul_done, verdict;
  logic                fast_path, fast_prime, base_skip, pow_last, res_one, res_nm1;

  assign nm1        = n_q - 1'b1;
  assign base       = WORDSIZE'(MR_WITNESS[round_cnt]);
  assign fast_prime = (n_q == WORDSIZE'(2)) || (n_q == WORDSIZE'(3));
  assign fast_path  = (n_q < WORDSIZE'(2)) || !n_q[0] || fast_prime;
  assign base_skip  = (base >= nm1);
  assign res_one    = (mul_res == WORDSIZE'(1));
  assign res_nm1    = (mul_res == nm1);
  // Final multiply of the exponentiation: bit 0 done, with its multiply if the bit is set.
  assign pow_last   = mul_done && (bit_idx == '0) && (mul_phase || !d[bit_idx]);

  mr_mod_mul #(.WORDSIZE(WORDSIZE)) u_mul (
    .clk   (clk),
    .reset (reset),
    .start (mul_start),
    .a     (mul_a),
    .b     (mul_b),
    .n     (n_q),
    .done  (mul_done),
    .res   (mul_res)
  );

  always_ff @(posedge clk) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE:   state_next = ST_DECOMP;
      ST_DECOMP: begin
        if (fast_path) state_next = ST_DONE;
        else if (d[0]) state_next = ST_POW;
      end
      ST_POW: begin
        if (base_skip) state_next = ST_NEXT;
        else if (pow_last) state_next = (res_one || res_nm1) ? ST_NEXT : ST_SQR;
      end
      ST_SQR: begin
        if (!mul_busy && sq_left == '0) state_next = ST_DONE;
        else if (mul_done && res_nm1)   state_next = ST_NEXT;
        else if (mul_done && res_one)   state_next = ST_DONE;
      end
      ST_NEXT:   state_next = (round_cnt + 4'd1 >= rounds_q) ? ST_DONE : ST_POW;
      ST_DONE:   state_next = ST_DONE;
      default:   state_next = ST_IDLE;
    endcase
  end

  always_comb begin
    bus.finish = (state == ST_DONE);
    bus.prime  = (state == ST_DONE) && verdict;
    mul_start  = 1'b0;
    mul_a      = x;
    mul_b      = x;
    case (state)
      ST_POW: begin
        mul_start = !mul_busy && !base_skip;
        if (mul_phase) mul_b = base;
      end
      ST_SQR:  mul_start = !mul_busy && (sq_left != '0);
      default: ;
    endcase
  end

`ifdef MR_ROUND_COUNT_EN
  assign bus.rounds_done = round_cnt;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      n_q       <= '0;
      rounds_q  <= 4'd1;
      d         <= '0;
      s         <= '0;
      x         <= '0;
      bit_idx   <= '0;
      mul_phase <= 1'b0;
      mul_busy  <= 1'b0;
      sq_left   <= '0;
      round_cnt <= '0;
      verdict   <= 1'b0;
    end else begin
      if (mul_start)     mul_busy <= 1'b1;
      else if (mul_done) mul_busy <= 1'b0;

      case (state)
        ST_IDLE: begin
          n_q       <= bus.start_number;
          rounds_q  <= mr_clamp_rounds(128'(bus.accuracy));
          d         <= bus.start_number - 1'b1;
          s         <= '0;
          round_cnt <= '0;
        end
        ST_DECOMP: begin
          if (!fast_path && !d[0]) begin
            d <= d >> 1;
            s <= s + 7'd1;
          end
        end
        ST_POW: begin
          if (mul_done) begin
            x <= mul_res;
            if (!mul_phase && d[bit_idx]) begin
              mul_phase <= 1'b1;
            end else begin
              mul_phase <= 1'b0;
              if (bit_idx != '0) bit_idx <= bit_idx - 1'b1;
            end
          end
        end
        ST_SQR: begin
          if (mul_done) begin
            x       <= mul_res;
            sq_left <= sq_left - 7'd1;
          end
        end
        ST_NEXT: round_cnt <= round_cnt + 4'd1;
        default: ;
      endcase

      // Every round starts its exponentiation from x = 1 at the top exponent bit.
      if (state_next == ST_POW && state != ST_POW) begin
        x         <= WORDSIZE'(1);
        bit_idx   <= BIT_TOP;
        mul_phase <= 1'b0;
      end
      if (state == ST_POW && state_next == ST_SQR) sq_left <= s - 7'd1;
      if (state_next == ST_DONE && state != ST_DONE)
        verdict <= (state == ST_NEXT) || (state == ST_DECOMP && fast_prime);
    end
  end

endmodule

// File: tb/tb_miller_rabin_core.sv
// Directed vector bench for miller_rabin_core (build with MR_ROUND_COUNT_EN to also check rounds_done).
module tb_miller_rabin_core;
  localparam int W     = 31;
  localparam int LIMIT = 40000;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  miller_rabin_core_if #(.WORDSIZE(W)) bus();
  miller_rabin_core #(.WORDSIZE(W)) dut (.clk(clk), .reset(reset), .bus(bus));

  typedef struct {
    logic [W-1:0]   n;
    logic [2*W-1:0] acc;
    logic           exp_prime;
    logic [3:0]     exp_rounds;
    int             exp_lat;   // -1: latency not checked
  } vec_t;

  vec_t vecs[16];
  int   applied = 0;
  int   miscompares = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    applied++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic wait_finish(output int lat, output bit leak);
    lat  = 0;
    leak = 1'b0;
    while (bus.finish !== 1'b1 && lat < LIMIT) begin
      if (bus.prime !== 1'b0) leak = 1'b1;
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic start_test(input logic [W-1:0] n, input logic [2*W-1:0] acc);
    @(negedge clk);
    reset = 1'b1;
    bus.start_number = n;
    bus.accuracy     = acc;
    @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    int  lat;
    bit  leak;

    vecs[0]  = '{31'd3,          62'd5,   1'b1, 4'd0,  2};
    vecs[1]  = '{31'd2,          62'd1,   1'b1, 4'd0,  2};
    vecs[2]  = '{31'd0,          62'd1,   1'b0, 4'd0,  2};
    vecs[3]  = '{31'd1,          62'd3,   1'b0, 4'd0,  2};
    vecs[4]  = '{31'd100,        62'd1,   1'b0, 4'd0,  2};
    vecs[5]  = '{31'd2047,       62'd1,   1'b1, 4'd1, -1};
    vecs[6]  = '{31'd2047,       62'd2,   1'b0, 4'd1, -1};
    vecs[7]  = '{31'd561,        62'd1,   1'b0, 4'd0, -1};
    vecs[8]  = '{31'd7,          62'd0,   1'b1, 4'd1, -1};
    vecs[9]  = '{31'd9,          62'd1,   1'b0, 4'd0, -1};
    vecs[10] = '{31'd25,         62'd1,   1'b0, 4'd0, -1};
    vecs[11] = '{31'd5,          62'd12,  1'b1, 4'd12, -1};
    vecs[12] = '{31'd13,         {62{1'b1}}, 1'b1, 4'd12, -1};
    vecs[13] = '{31'd15,         62'd0,   1'b0, 4'd0, -1};
    vecs[14] = '{31'd2147483647, 62'd3,   1'b1, 4'd3, -1};
    vecs[15] = '{31'd2147483647, 62'd12,  1'b1, 4'd12, -1};

    bus.start_number = '0;
    bus.accuracy     = '0;
    @(negedge clk);
    @(negedge clk);
    check("reset_finish", 64'(bus.finish), 64'd0);
    check("reset_prime",  64'(bus.prime),  64'd0);

    for (int i = 0; i < 16; i++) begin
      start_test(vecs[i].n, vecs[i].acc);
      wait_finish(lat, leak);
      check($sformatf("v%0d_finish", i), 64'(bus.finish), 64'd1);
      check($sformatf("v%0d_prime n=%0d", i, vecs[i].n), 64'(bus.prime), 64'(vecs[i].exp_prime));
      check($sformatf("v%0d_no_early_prime", i), 64'(leak), 64'd0);
      if (vecs[i].exp_lat >= 0)
        check($sformatf("v%0d_latency", i), 64'(lat), 64'(vecs[i].exp_lat));
`ifdef MR_ROUND_COUNT_EN
      check($sformatf("v%0d_rounds_done", i), 64'(bus.rounds_done), 64'(vecs[i].exp_rounds));
`endif
    end

    // Operand change while finished is ignored; a one-cycle reset retests the new n.
    start_test(31'd7, 62'd1);
    wait_finish(lat, leak);
    check("hold_prime_before", 64'(bus.prime), 64'd1);
    bus.start_number = 31'd9;
    repeat (3) @(negedge clk);
    check("hold_finish_after_change", 64'(bus.finish), 64'd1);
    check("hold_prime_after_change",  64'(bus.prime),  64'd1);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("finish_drops_on_reset", 64'(bus.finish), 64'd0);
    check("prime_drops_on_reset",  64'(bus.prime),  64'd0);
    wait_finish(lat, leak);
    check("retest_finish", 64'(bus.finish), 64'd1);
    check("retest_prime_n9", 64'(bus.prime), 64'd0);

    // Abort a long test mid-exponentiation, then restart cleanly.
    start_test(31'd2147483647, 62'd12);
    lat  = 0;
    leak = 1'b0;
    repeat (300) begin
      @(negedge clk);
      if (bus.finish !== 1'b0 || bus.prime !== 1'b0) leak = 1'b1;
    end
    check("midpow_no_output", 64'(leak), 64'd0);
    start_test(31'd2047, 62'd1);
    check("abort_finish_low", 64'(bus.finish), 64'd0);
    wait_finish(lat, leak);
    check("restart_finish", 64'(bus.finish), 64'd1);
    check("restart_prime",  64'(bus.prime),  64'd1);
`ifdef MR_ROUND_COUNT_EN
    check("restart_rounds_done", 64'(bus.rounds_done), 64'd1);
`endif

    start_test(31'd3, 62'd1);
    wait_finish(lat, leak);
    check("restart_fast_latency", 64'(lat), 64'd2);
    check("restart_fast_prime", 64'(bus.prime), 64'd1);

    $display("== %0d vectors applied, %0d miscompares ==", applied, miscompares);
    $finish;
  end

endmodule
